// File: rtl/digit_display_pkg.sv
// Shared bus-peripheral definitions: display register offsets, the blank
// segment pattern and the offset-to-register decode used by the display.
package digit_display_pkg;

  localparam logic [2:0]  ADDR_DATA_LO = 3'b000;
  localparam logic [2:0]  ADDR_DATA_HI = 3'b010;
  localparam logic [2:0]  ADDR_CTRL    = 3'b100;

  localparam logic [7:0]  SEG_BLANK    = 8'hFF;
  localparam logic [7:0]  DIGIT_OFF    = 8'hFF;
  localparam logic [15:0] RDATA_IDLE   = 16'h0000;

  typedef enum logic [1:0] {
    REG_NONE    = 2'd0,
    REG_DATA_LO = 2'd1,
    REG_DATA_HI = 2'd2,
    REG_CTRL    = 2'd3
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [2:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_DATA_LO: sel = REG_DATA_LO;
      ADDR_DATA_HI: sel = REG_DATA_HI;
      ADDR_CTRL:    sel = REG_CTRL;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/digit_display_if.sv
// CPU-side register bus of the digit display (strobes, chip-select, address,
// write data and registered readback).
interface digit_display_if;
  logic        write_enable;
  logic        displayCtrl;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] write_data_input;
  logic [15:0] read_data_output;

  modport master (
    output write_enable, displayCtrl, read_enable, address, write_data_input,
    input  read_data_output
  );

  modport slave (
    input  write_enable, displayCtrl, read_enable, address, write_data_input,
    output read_data_output
  );
endinterface

// File: rtl/digit_display_seg7_decode.sv
// Hex nibble to active-low gfedcba seven-segment pattern.
module seg7_decode (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  // pure lookup, no state
  always_comb begin
    case (hex_i)
      4'h0:    seg_n_o = 7'h40;
      4'h1:    seg_n_o = 7'h79;
      4'h2:    seg_n_o = 7'h24;
      4'h3:    seg_n_o = 7'h30;
      4'h4:    seg_n_o = 7'h19;
      4'h5:    seg_n_o = 7'h12;
      4'h6:    seg_n_o = 7'h02;
      4'h7:    seg_n_o = 7'h78;
      4'h8:    seg_n_o = 7'h00;
      4'h9:    seg_n_o = 7'h10;
      4'hA:    seg_n_o = 7'h08;
      4'hB:    seg_n_o = 7'h03;
      4'hC:    seg_n_o = 7'h46;
      4'hD:    seg_n_o = 7'h21;
      4'hE:    seg_n_o = 7'h06;
      4'hF:    seg_n_o = 7'h0E;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/digit_display.sv
// Eight-digit multiplexed seven-segment display controller on the CPU bus.
// Optional register readback is enabled by defining DIGIT_DISPLAY_READBACK_EN.
module digit_display
  import digit_display_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic            clock,
  input  logic            reset,
  digit_display_if.slave  bus,
  output logic [7:0]      digit_enable,
  output logic [7:0]      segment
);

  localparam logic [15:0] TERM_CNT = SCAN_DIV - 16'd1;

  logic        wr_s;
  reg_sel_e    wr_sel_s;
  logic        terminal_s;
  logic [15:0] nib_word_s;
  logic [3:0]  nibble_s;
  logic [6:0]  hex_seg_s;
  logic [7:0]  en_mask_s;
  logic [7:0]  dp_mask_s;

  logic [15:0] data_lo_q, data_lo_d;
  logic [15:0] data_hi_q, data_hi_d;
  logic [15:0] ctrl_q,    ctrl_d;
  logic [15:0] presc_q,   presc_d;
  logic [2:0]  idx_q,     idx_d;
  logic [7:0]  digit_enable_q, digit_enable_d;
  logic [7:0]  segment_q,      segment_d;
  logic [15:0] rdata_q,        rdata_d;

  assign wr_s     = bus.displayCtrl & bus.write_enable;
  assign wr_sel_s = decode_addr(bus.address);

  always_comb begin
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    ctrl_d    = ctrl_q;
    if (wr_s) begin
      case (wr_sel_s)
        REG_DATA_LO: data_lo_d = bus.write_data_input;
        REG_DATA_HI: data_hi_d = bus.write_data_input;
        REG_CTRL:    ctrl_d    = bus.write_data_input;
        default:     ctrl_d    = ctrl_q;
      endcase
    end else begin
      data_lo_d = data_lo_q;
      data_hi_d = data_hi_q;
      ctrl_d    = ctrl_q;
    end
  end

  // scan timing is independent of bus traffic; SCAN_DIV=1 makes every edge terminal
  assign terminal_s = (presc_q == TERM_CNT);

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (terminal_s) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
    end
  end

  assign en_mask_s  = ctrl_q[7:0];
  assign dp_mask_s  = ctrl_q[15:8];
  assign nib_word_s = idx_q[2] ? data_hi_q : data_lo_q;
  assign nibble_s   = nib_word_s[{idx_q[1:0], 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .hex_i   (nibble_s),
    .seg_n_o (hex_seg_s)
  );

  always_comb begin
    digit_enable_d = DIGIT_OFF;
    segment_d      = SEG_BLANK;
    if (en_mask_s[idx_q]) begin
      digit_enable_d = ~(8'b0000_0001 << idx_q);
      segment_d      = {~dp_mask_s[idx_q], hex_seg_s};
    end else begin
      digit_enable_d = DIGIT_OFF;
      segment_d      = SEG_BLANK;
    end
  end

`ifdef DIGIT_DISPLAY_READBACK_EN
  logic     rd_s;
  reg_sel_e rd_sel_s;

  assign rd_s     = bus.displayCtrl & bus.read_enable;
  assign rd_sel_s = decode_addr(bus.address);

  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      case (rd_sel_s)
        REG_DATA_LO: rdata_d = data_lo_q;
        REG_DATA_HI: rdata_d = data_hi_q;
        REG_CTRL:    rdata_d = ctrl_q;
        default:     rdata_d = RDATA_IDLE;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end
`else
  always_comb begin
    rdata_d = RDATA_IDLE;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_lo_q      <= 16'h0000;
      data_hi_q      <= 16'h0000;
      ctrl_q         <= 16'h0000;
      presc_q        <= 16'd0;
      idx_q          <= 3'd0;
      digit_enable_q <= DIGIT_OFF;
      segment_q      <= SEG_BLANK;
      rdata_q        <= RDATA_IDLE;
    end else begin
      data_lo_q      <= data_lo_d;
      data_hi_q      <= data_hi_d;
      ctrl_q         <= ctrl_d;
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      digit_enable_q <= digit_enable_d;
      segment_q      <= segment_d;
      rdata_q        <= rdata_d;
    end
  end

  assign bus.read_data_output = rdata_q;
  assign digit_enable         = digit_enable_q;
  assign segment              = segment_q;

endmodule
